mmio_uart_ctrl: RTL and testbench

- Memory-mapped I/O controller between the CPU memory stage and the on-chip uart. Handles CPU loads and stores in the I/O region (addr[31:28] == 4'h8).
- Sequences the uart ready/valid handshakes. Buffers received bytes in a small FIFO.
- Keeps the cycle and retired-instruction counters used by software benchmarks.
- Read data is registered, giving the same one-cycle load latency as dmem. The writeback mux therefore needs no special case.

---
 rtl/mmio_pkg.sv | 19 +
 rtl/io_rx_fifo.sv | 65 ++++++
 rtl/mmio_uart_ctrl.sv | 115 +++++++++++
 tb/tb_mmio_uart_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped I/O block: region tag, register
// offsets and the TX handshake state encoding.
package mmio_pkg;

  localparam logic [3:0] MMIO_REGION    = 4'h8;

  localparam logic [7:0] MMIO_STATUS    = 8'h00;
  localparam logic [7:0] MMIO_RX_DATA   = 8'h04;
  localparam logic [7:0] MMIO_TX_DATA   = 8'h08;
  localparam logic [7:0] MMIO_CYCLE_CNT = 8'h10;
  localparam logic [7:0] MMIO_INST_CNT  = 8'h14;
  localparam logic [7:0] MMIO_CNT_RST   = 8'h18;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_PEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/io_rx_fifo.sv
// Synchronous FIFO buffering bytes received from the uart. Pointers wrap
// naturally (power-of-two depth); a one-bit-wider count separates full from empty.
module io_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  // NOTE: every variable gets its hold value first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// CPU-facing I/O register block: uart TX handshake, buffered RX, and the
// cycle/instruction benchmark counters, with registered load data.
module mmio_uart_ctrl
  import mmio_pkg::*;
#(
  parameter int RX_FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_en,
  input  logic        io_we,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_wdata,
  input  logic        inst_retired,
  output logic [31:0] io_rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  localparam int PTR_W = $clog2(RX_FIFO_DEPTH);

  tx_state_e   tx_state_q, tx_state_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] inst_cnt_q, inst_cnt_d;

  logic        io_load, io_store, cnt_rst;
  logic        rx_pop, rx_full, rx_empty;
  logic [7:0]  rx_head;
  logic        tx_free, rx_avail;
  logic        unused_wdata;

  assign io_load      = io_en && !io_we;
  assign io_store     = io_en && io_we;
  assign cnt_rst      = io_store && (io_addr == MMIO_CNT_RST);
  assign rx_pop       = io_load && (io_addr == MMIO_RX_DATA);
  assign tx_free      = (tx_state_q == TX_IDLE);
  assign rx_avail     = !rx_empty;
  assign unused_wdata = ^io_wdata[31:8];

  io_rx_fifo #(
    .DEPTH (RX_FIFO_DEPTH),
    .WIDTH (8),
    .PTR_W (PTR_W)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (uart_rx_valid),
    .push_data (uart_rx_data),
    .pop       (rx_pop),
    .pop_data  (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // Stores to TX data while a byte is pending are dropped so the byte stays stable.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    case (tx_state_q)
      TX_IDLE: if (io_store && io_addr == MMIO_TX_DATA) begin
        tx_state_d = TX_PEND;
        tx_data_d  = io_wdata[7:0];
      end
      TX_PEND: if (uart_tx_ready) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    cycle_cnt_d = cnt_rst ? 32'd0 : cycle_cnt_q + 32'd1;
    inst_cnt_d  = cnt_rst ? 32'd0 : inst_cnt_q + {31'd0, inst_retired};
  end

  // Load data reflects pre-edge state and holds between loads.
  always_comb begin
    rdata_d = rdata_q;
    if (io_load) begin
      case (io_addr)
        MMIO_STATUS:    rdata_d = {30'd0, rx_avail, tx_free};
        MMIO_RX_DATA:   rdata_d = rx_empty ? 32'd0 : {24'd0, rx_head};
        MMIO_CYCLE_CNT: rdata_d = cycle_cnt_q;
        MMIO_INST_CNT:  rdata_d = inst_cnt_q;
        default:        rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q  <= TX_IDLE;
      tx_data_q   <= '0;
      rdata_q     <= '0;
      cycle_cnt_q <= '0;
      inst_cnt_q  <= '0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_data_q   <= tx_data_d;
      rdata_q     <= rdata_d;
      cycle_cnt_q <= cycle_cnt_d;
      inst_cnt_q  <= inst_cnt_d;
    end
  end

  assign io_rdata      = rdata_q;
  assign uart_tx_data  = tx_data_q;
  assign uart_tx_valid = (tx_state_q == TX_PEND);
  assign uart_rx_ready = !rx_full;

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Self-checking bench for mmio_uart_ctrl: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_mmio_uart_ctrl;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_en, io_we;
  logic [7:0]  io_addr;
  logic [31:0] io_wdata;
  logic        inst_retired;
  logic [31:0] io_rdata;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid, uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid, uart_rx_ready;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_rdata, m_cyc, m_inst;
  logic        m_pend;
  logic [7:0]  m_txb;
  logic [7:0]  m_rxq [$];

  mmio_uart_ctrl #(.RX_FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .io_en         (io_en),
    .io_we         (io_we),
    .io_addr       (io_addr),
    .io_wdata      (io_wdata),
    .inst_retired  (inst_retired),
    .io_rdata      (io_rdata),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready)
  );

  always #5 clk = ~clk;

  // Advance one clock: model computes from current inputs, DUT takes the edge,
  // then the uart side drops rx_valid once its byte was accepted.
  task automatic step();
    logic [31:0] n_rdata = m_rdata;
    logic [31:0] n_cyc   = m_cyc;
    logic [31:0] n_inst  = m_inst;
    logic        n_pend  = m_pend;
    logic [7:0]  n_txb   = m_txb;
    logic        do_pop  = 1'b0;
    logic        do_push = 1'b0;
    logic        ld, st;
    ld = io_en && !io_we;
    st = io_en && io_we;
    if (rst) begin
      n_rdata = 0; n_cyc = 0; n_inst = 0; n_pend = 0; n_txb = 0;
    end else begin
      if (ld) begin
        if (io_addr == 8'h00)      n_rdata = {30'd0, m_rxq.size() > 0, !m_pend};
        else if (io_addr == 8'h04) n_rdata = (m_rxq.size() > 0) ? {24'd0, m_rxq[0]} : 32'd0;
        else if (io_addr == 8'h10) n_rdata = m_cyc;
        else if (io_addr == 8'h14) n_rdata = m_inst;
        else                       n_rdata = 0;
      end
      do_pop  = ld && io_addr == 8'h04 && m_rxq.size() > 0;
      do_push = uart_rx_valid && m_rxq.size() < DEPTH;
      if (m_pend) begin
        if (uart_tx_ready) n_pend = 0;
      end else if (st && io_addr == 8'h08) begin
        n_pend = 1; n_txb = io_wdata[7:0];
      end
      if (st && io_addr == 8'h18) begin
        n_cyc = 0; n_inst = 0;
      end else begin
        n_cyc = m_cyc + 1; n_inst = m_inst + 32'(inst_retired);
      end
    end
    @(posedge clk);
    #1;
    m_rdata = n_rdata; m_cyc = n_cyc; m_inst = n_inst; m_pend = n_pend; m_txb = n_txb;
    if (rst) m_rxq.delete();
    else begin
      if (do_pop)  void'(m_rxq.pop_front());
      if (do_push) m_rxq.push_back(uart_rx_data);
    end
    if (do_push) uart_rx_valid = 1'b0;
  endtask

  task automatic load(input logic [7:0] addr);
    io_en = 1; io_we = 0; io_addr = addr;
    step();
    io_en = 0;
  endtask

  task automatic store(input logic [7:0] addr, input logic [31:0] data);
    io_en = 1; io_we = 1; io_addr = addr; io_wdata = data;
    step();
    io_en = 0; io_we = 0;
  endtask

  task automatic test_reset();
    rst = 1; io_en = 0; io_we = 0; io_addr = 0; io_wdata = 0; inst_retired = 0;
    uart_tx_ready = 0; uart_rx_valid = 0; uart_rx_data = 0;
    m_rxq.delete();
    step(); step();
    rst = 0;
    checks++; if (io_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", io_rdata); end
    checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", uart_tx_valid); end
    checks++; if (uart_tx_data !== 8'd0) begin errors++; $display("FAIL reset_tx_data got %h exp 0", uart_tx_data); end
    checks++; if (uart_rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready got %b exp 1", uart_rx_ready); end
    load(8'h00);
    checks++; if (io_rdata !== 32'h1) begin errors++; $display("FAIL reset_status got %h exp 1", io_rdata); end
    load(8'h10);
    checks++; if (io_rdata !== 32'd1) begin errors++; $display("FAIL reset_cycle got %h exp 1", io_rdata); end
    load(8'h14);
    checks++; if (io_rdata !== 32'd0) begin errors++; $display("FAIL reset_inst got %h exp 0", io_rdata); end
  endtask

  task automatic test_tx();
    uart_tx_ready = 0;
    store(8'h08, 32'hDEAD_BE41);
    for (int i = 0; i < 3; i++) begin
      load(8'h00);
      checks++; if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h41) begin
        errors++; $display("FAIL tx_pend cyc%0d got v=%b d=%h exp v=1 d=41", i, uart_tx_valid, uart_tx_data);
      end
      checks++; if (io_rdata !== 32'h0) begin errors++; $display("FAIL tx_status_busy got %h exp 0", io_rdata); end
    end
    store(8'h08, 32'h42);
    checks++; if (uart_tx_data !== 8'h41 || uart_tx_valid !== 1'b1) begin
      errors++; $display("FAIL tx_drop got v=%b d=%h exp v=1 d=41", uart_tx_valid, uart_tx_data);
    end
    uart_tx_ready = 1;
    step();
    uart_tx_ready = 0;
    checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL tx_done got %b exp 0", uart_tx_valid); end
    load(8'h00);
    checks++; if (io_rdata !== 32'h1) begin errors++; $display("FAIL tx_status_free got %h exp 1", io_rdata); end
  endtask

  task automatic test_rx_full();
    for (int i = 0; i < DEPTH; i++) begin
      uart_rx_valid = 1; uart_rx_data = 8'(8'h10 + i);
      step();
    end
    checks++; if (uart_rx_ready !== 1'b0) begin errors++; $display("FAIL rx_full_ready got %b exp 0", uart_rx_ready); end
    uart_rx_valid = 1; uart_rx_data = 8'h18;
    step(); step();
    checks++; if (uart_rx_ready !== 1'b0 || uart_rx_valid !== 1'b1) begin
      errors++; $display("FAIL rx_hold got ready=%b pending=%b exp ready=0 pending=1", uart_rx_ready, uart_rx_valid);
    end
    for (int i = 0; i < DEPTH; i++) begin
      load(8'h04);
      checks++; if (io_rdata !== 32'(8'h10 + i)) begin
        errors++; $display("FAIL rx_order%0d got %h exp %h", i, io_rdata, 8'h10 + i);
      end
    end
    load(8'h04);
    checks++; if (io_rdata !== 32'h18) begin errors++; $display("FAIL rx_late got %h exp 18", io_rdata); end
    load(8'h04);
    checks++; if (io_rdata !== 32'h0) begin errors++; $display("FAIL rx_empty_load got %h exp 0", io_rdata); end
    load(8'h00);
    checks++; if (io_rdata !== 32'h1) begin errors++; $display("FAIL rx_empty_status got %h exp 1", io_rdata); end
  endtask

  task automatic test_simul();
    uart_rx_valid = 1; uart_rx_data = 8'h55;
    step();
    uart_rx_valid = 1; uart_rx_data = 8'hAA;
    load(8'h04);
    checks++; if (io_rdata !== 32'h55) begin errors++; $display("FAIL simul_first got %h exp 55", io_rdata); end
    load(8'h04);
    checks++; if (io_rdata !== 32'hAA) begin errors++; $display("FAIL simul_second got %h exp aa", io_rdata); end
    load(8'h00);
    checks++; if (io_rdata !== 32'h1) begin errors++; $display("FAIL simul_status got %h exp 1", io_rdata); end
  endtask

  task automatic test_counters();
    logic [9:0] pat;
    store(8'h18, $urandom);
    load(8'h10);
    checks++; if (io_rdata !== 32'd0) begin errors++; $display("FAIL cnt_rst_cycle0 got %h exp 0", io_rdata); end
    load(8'h10);
    checks++; if (io_rdata !== 32'd1) begin errors++; $display("FAIL cnt_rst_cycle1 got %h exp 1", io_rdata); end
    load(8'h14);
    checks++; if (io_rdata !== 32'd0) begin errors++; $display("FAIL cnt_rst_inst got %h exp 0", io_rdata); end
    do pat = 10'($urandom_range(0, 1023)); while ($countones(pat) != 5);
    store(8'h18, 32'h0);
    for (int i = 0; i < 10; i++) begin
      inst_retired = pat[i];
      step();
    end
    inst_retired = 0;
    load(8'h14);
    checks++; if (io_rdata !== 32'd5) begin errors++; $display("FAIL inst_count got %0d exp 5", io_rdata); end
    load(8'h10);
    checks++; if (io_rdata !== 32'd11) begin errors++; $display("FAIL cycle_elapsed got %0d exp 11", io_rdata); end
    @(negedge clk);
    force dut.cycle_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt_q;
    m_cyc = 32'hFFFF_FFFF;
    load(8'h10);
    checks++; if (io_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cycle_max got %h exp ffffffff", io_rdata); end
    load(8'h10);
    checks++; if (io_rdata !== 32'd0) begin errors++; $display("FAIL cycle_wrap got %h exp 0", io_rdata); end
  endtask

  task automatic test_reset_mid();
    uart_tx_ready = 0;
    store(8'h08, 32'h77);
    for (int i = 0; i < 3; i++) begin
      uart_rx_valid = 1; uart_rx_data = 8'(8'hC0 + i);
      step();
    end
    checks++; if (uart_tx_valid !== 1'b1) begin errors++; $display("FAIL mid_pend got %b exp 1", uart_tx_valid); end
    rst = 1;
    step();
    rst = 0;
    checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL mid_tx_valid got %b exp 0", uart_tx_valid); end
    load(8'h00);
    checks++; if (io_rdata !== 32'h1) begin errors++; $display("FAIL mid_status got %h exp 1", io_rdata); end
    load(8'h04);
    checks++; if (io_rdata !== 32'h0) begin errors++; $display("FAIL mid_rx got %h exp 0", io_rdata); end
  endtask

  task automatic test_random();
    logic [7:0] addrs [8] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h0C, 8'h04};
    for (int n = 0; n < 600; n++) begin
      uart_tx_ready = ($urandom_range(0, 3) == 0);
      inst_retired  = $urandom_range(0, 1);
      if (!uart_rx_valid && $urandom_range(0, 2) == 0) begin
        uart_rx_valid = 1; uart_rx_data = 8'($urandom);
      end
      io_en    = ($urandom_range(0, 1) == 1);
      io_we    = ($urandom_range(0, 3) == 0);
      io_addr  = ($urandom_range(0, 15) == 0) ? 8'($urandom) : addrs[$urandom_range(0, 7)];
      if (io_we && io_addr == 8'h18 && $urandom_range(0, 3) != 0) io_addr = 8'h08;
      io_wdata = $urandom;
      step();
      checks++; if (io_rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata n=%0d got %h exp %h", n, io_rdata, m_rdata); end
      checks++; if (uart_tx_valid !== m_pend) begin errors++; $display("FAIL rnd_tx_valid n=%0d got %b exp %b", n, uart_tx_valid, m_pend); end
      checks++; if (uart_tx_data !== m_txb) begin errors++; $display("FAIL rnd_tx_data n=%0d got %h exp %h", n, uart_tx_data, m_txb); end
      checks++; if (uart_rx_ready !== (m_rxq.size() < DEPTH)) begin
        errors++; $display("FAIL rnd_rx_ready n=%0d got %b exp %b", n, uart_rx_ready, m_rxq.size() < DEPTH);
      end
    end
    io_en = 0; io_we = 0; uart_tx_ready = 0; inst_retired = 0;
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx_full();
    test_simul();
    test_counters();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
